// File: rtl/bip_tx_sequencer.sv
// BIP run/report controller: gates the CPU clock-enable, counts enabled cycles and,
// on halt, streams {acc, pc, cycles} to the UART. Optional XOR checksum byte: BIP_TX_CHECKSUM_EN.
module bip_tx_sequencer #(
  parameter int NB_DATA   = 16,
  parameter int NB_PC     = 11,
  parameter int NB_BYTE   = 8,
  parameter int NB_CYCLES = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_halt,
  input  logic [NB_DATA-1:0] i_acc,
  input  logic [NB_PC-1:0]   i_pc,
  input  logic               i_tx_done,
  output logic               o_cpu_en,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_done
);

  localparam int NB_FRAME = 2 * NB_DATA + NB_CYCLES;
  localparam int NB_IDX   = 4;
`ifdef BIP_TX_CHECKSUM_EN
  localparam logic [NB_IDX-1:0] LAST_IDX = 4'd8;
`else
  localparam logic [NB_IDX-1:0] LAST_IDX = 4'd7;
`endif
  localparam logic [NB_CYCLES-1:0] CYC_ONE = {{(NB_CYCLES-1){1'b0}}, 1'b1};
  localparam logic [NB_IDX-1:0]    IDX_ONE = {{(NB_IDX-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  cpu_en_q, cpu_en_d;
  logic                  tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0]    tx_data_q, tx_data_d;
  logic                  done_q, done_d;
  logic [NB_CYCLES-1:0]  cycles_q, cycles_d;
  logic [NB_IDX-1:0]     idx_q, idx_d;
  logic [NB_FRAME-1:0]   frame_q, frame_d;
`ifdef BIP_TX_CHECKSUM_EN
  logic [NB_BYTE-1:0]    csum_q, csum_d;
`endif

  function automatic logic [NB_CYCLES-1:0] sat_inc(input logic [NB_CYCLES-1:0] v);
    return (&v) ? v : v + CYC_ONE;
  endfunction

  // Byte 0 is the most significant byte of the frame.
  function automatic logic [NB_BYTE-1:0] frame_byte(input logic [NB_FRAME-1:0] f,
                                                    input logic [2:0]          i);
    logic [5:0] base;
    base = {~i, 3'b000};
    return f[base +: NB_BYTE];
  endfunction

  always_comb begin
    state_d    = state_q;
    cpu_en_d   = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done_d     = done_q;
    cycles_d   = cycles_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
`ifdef BIP_TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (cpu_en_q) cycles_d = sat_inc(cycles_q);

    case (state_q)
      S_IDLE: begin
        if (i_valid) state_d = S_RUN;
      end
      S_RUN: begin
        // Halt only counts when the CPU actually executed this cycle; the
        // latched count therefore includes the halt cycle itself.
        if (cpu_en_q && i_halt) begin
          frame_d = {i_acc, {(NB_DATA-NB_PC){1'b0}}, i_pc, cycles_d};
          idx_d   = '0;
          state_d = S_LOAD;
`ifdef BIP_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end else begin
          cpu_en_d = i_valid;
        end
      end
      S_LOAD: begin
`ifdef BIP_TX_CHECKSUM_EN
        if (idx_q == LAST_IDX) begin
          tx_data_d = csum_q;
        end else begin
          tx_data_d = frame_byte(frame_q, idx_q[2:0]);
          csum_d    = csum_q ^ tx_data_d;
        end
`else
        tx_data_d = frame_byte(frame_q, idx_q[2:0]);
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_start_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cpu_en_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      cycles_q   <= '0;
      idx_q      <= '0;
`ifdef BIP_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cpu_en_q   <= cpu_en_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      cycles_q   <= cycles_d;
      idx_q      <= idx_d;
`ifdef BIP_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // The snapshot is only meaningful once written on halt, so it needs no reset.
  always_ff @(posedge i_clk) begin
    frame_q <= frame_d;
  end

  assign o_cpu_en   = cpu_en_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_done     = done_q;

endmodule
